music_channel_selector: RTL and testbench

Parametrised successor to the 4-way song selector. Routes playback to one of NUM_CH song-player blocks. It drives a one-hot clock-enable vector instead of gated clocks, and inserts a muted gap on every channel change. It then issues a one-cycle restart pulse so the new song starts from its first note. The block sits between the front-panel button logic and the song-player bank, with all logic on the single system clock.

---
 rtl/music_channel_selector.sv | 134 +++++++++++++
 tb/tb_music_channel_selector.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/music_channel_selector.sv
// Routes playback to one of NUM_CH song players via one-hot clock enables,
// with a muted gap and restart pulse on every change. Option: MUSIC_SEL_AUTO_ADVANCE_EN.
module music_channel_selector #(
    parameter  int NUM_CH     = 4,
    parameter  int GAP_CYCLES = 16,
    parameter  int RESET_CH   = 0,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic              clock_in,
    input  logic              reset,
    input  logic              sel_load,
    input  logic [SEL_W-1:0]  sel_idx,
    input  logic              btn_next,
    input  logic [NUM_CH-1:0] song_done,
    output logic [NUM_CH-1:0] ch_enable,
    output logic [NUM_CH-1:0] ch_restart,
    output logic [SEL_W-1:0]  cur_ch,
    output logic              switching
);

    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(NUM_CH - 1);
    localparam logic [SEL_W-1:0] RST_CH   = SEL_W'(RESET_CH);

    if (GAP_CYCLES < 1) begin : g_bad_gap
        $error("GAP_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        INIT,
        START,
        PLAY,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  cur_q, cur_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sel_ok;
    logic              req;
    logic [SEL_W-1:0]  tgt;
    logic [SEL_W-1:0]  nxt_ch;
    logic              auto_req;
    logic [NUM_CH-1:0] ch_onehot;

    assign sel_ok    = {1'b0, sel_idx} < (SEL_W + 1)'(NUM_CH);
    assign nxt_ch    = (cur_q == LAST_CH) ? '0 : cur_q + 1'b1;
    assign ch_onehot = {{(NUM_CH - 1){1'b0}}, 1'b1} << cur_q;

`ifdef MUSIC_SEL_AUTO_ADVANCE_EN
    assign auto_req = (state_q == PLAY) && song_done[cur_q];
`else
    logic unused_song_done;
    assign unused_song_done = ^song_done;
    assign auto_req         = 1'b0;
`endif

    // State, channel and gap counter registers
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q <= INIT;
            cur_q   <= RST_CH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request priority decode: direct load, then next button, then auto
    always_comb begin
        req = 1'b0;
        tgt = cur_q;
        if (sel_load && sel_ok) begin
            req = 1'b1;
            tgt = sel_idx;
        end else if (btn_next) begin
            req = 1'b1;
            tgt = nxt_ch;
        end else if (auto_req) begin
            req = 1'b1;
            tgt = nxt_ch;
        end
    end

    // Next-state logic; requests only land in PLAY and GAP
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            INIT:  state_d = START;
            START: state_d = PLAY;
            PLAY: begin
                if (req) begin
                    state_d = GAP;
                    cur_d   = tgt;
                    cnt_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (req) begin
                    cur_d = tgt;
                    cnt_d = GAP_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = START;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Output decode from registered state and channel
    always_comb begin
        ch_enable  = '0;
        ch_restart = '0;
        switching  = 1'b1;
        unique case (state_q)
            START: ch_restart = ch_onehot;
            PLAY: begin
                ch_enable = ch_onehot;
                switching = 1'b0;
            end
            default: ;
        endcase
    end

    assign cur_ch = cur_q;

endmodule

// File: tb/tb_music_channel_selector.sv
// Scoreboard bench for music_channel_selector.
// NUM_CH=5, GAP_CYCLES=3, RESET_CH=0.
module tb_music_channel_selector;

    localparam int N = 5;
    localparam int G = 3;
    localparam int W = 3;

    logic         clock_in = 1'b0;
    logic         reset;
    logic         sel_load;
    logic [W-1:0] sel_idx;
    logic         btn_next;
    logic [N-1:0] song_done;
    logic [N-1:0] ch_enable;
    logic [N-1:0] ch_restart;
    logic [W-1:0] cur_ch;
    logic         switching;

    always #5 clock_in = ~clock_in;

    music_channel_selector #(
        .NUM_CH    (N),
        .GAP_CYCLES(G),
        .RESET_CH  (0)
    ) dut (
        .clock_in  (clock_in),
        .reset     (reset),
        .sel_load  (sel_load),
        .sel_idx   (sel_idx),
        .btn_next  (btn_next),
        .song_done (song_done),
        .ch_enable (ch_enable),
        .ch_restart(ch_restart),
        .cur_ch    (cur_ch),
        .switching (switching)
    );

    typedef enum int {K_INIT, K_START, K_PLAY, K_GAP} kind_t;
    typedef struct {
        kind_t k;
        int    ch;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   step_n = 0;

    // Count a comparison and report a mismatch
    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", tag, got, exp);
    endtask

    // Drive one cycle of inputs, push the expected post-edge view, then compare
    task automatic cyc(input logic r, input logic ld, input int idx,
                       input logic nx, input logic [N-1:0] sd,
                       input kind_t k, input int ch);
        exp_t         e;
        exp_t         p;
        logic [N-1:0] oh;
        reset     = r;
        sel_load  = ld;
        sel_idx   = W'(idx);
        btn_next  = nx;
        song_done = sd;
        e.k  = k;
        e.ch = ch;
        sb.push_back(e);
        @(posedge clock_in);
        #1;
        step_n++;
        p  = sb.pop_front();
        oh = N'(1) << p.ch;
        check($sformatf("s%0d.en", step_n), int'(ch_enable),
              (p.k == K_PLAY) ? int'(oh) : 0);
        check($sformatf("s%0d.rs", step_n), int'(ch_restart),
              (p.k == K_START) ? int'(oh) : 0);
        check($sformatf("s%0d.cur", step_n), int'(cur_ch), p.ch);
        check($sformatf("s%0d.sw", step_n), int'(switching),
              (p.k == K_PLAY) ? 0 : 1);
        check($sformatf("s%0d.excl", step_n),
              int'(ch_enable & ch_restart), 0);
    endtask

    task automatic idle(input kind_t k, input int ch);
        cyc(1'b0, 1'b0, 0, 1'b0, '0, k, ch);
    endtask

    // Remaining muted cycles after a request, restart, then play
    task automatic finish_gap(input int ch);
        idle(K_GAP, ch);
        idle(K_GAP, ch);
        idle(K_START, ch);
        idle(K_PLAY, ch);
    endtask

    initial begin
        // Reset, INIT ignores requests, START drops requests
        cyc(1'b1, 1'b0, 0, 1'b0, '0, K_INIT, 0);
        cyc(1'b1, 1'b1, 3, 1'b0, '0, K_INIT, 0);
        cyc(1'b0, 1'b0, 0, 1'b1, '0, K_START, 0);
        cyc(1'b0, 1'b1, 2, 1'b0, '0, K_PLAY, 0);
        idle(K_PLAY, 0);

        // Load ch3, step to ch4, step wraps to ch0
        cyc(1'b0, 1'b1, 3, 1'b0, '0, K_GAP, 3);
        finish_gap(3);
        cyc(1'b0, 1'b0, 0, 1'b1, '0, K_GAP, 4);
        finish_gap(4);
        cyc(1'b0, 1'b0, 0, 1'b1, '0, K_GAP, 0);
        finish_gap(0);

        // Out-of-range loads ignored
        cyc(1'b0, 1'b1, 6, 1'b0, '0, K_PLAY, 0);
        cyc(1'b0, 1'b1, 5, 1'b0, '0, K_PLAY, 0);
        idle(K_PLAY, 0);

        // Load beats next in the same cycle
        cyc(1'b0, 1'b1, 2, 1'b1, '0, K_GAP, 2);
        finish_gap(2);

        // Load of the current channel restarts it
        cyc(1'b0, 1'b1, 2, 1'b0, '0, K_GAP, 2);
        finish_gap(2);

        // Back to ch0, then a load mid-gap restarts the gap
        cyc(1'b0, 1'b1, 0, 1'b0, '0, K_GAP, 0);
        finish_gap(0);
        cyc(1'b0, 1'b0, 0, 1'b1, '0, K_GAP, 1);
        cyc(1'b0, 1'b1, 3, 1'b0, '0, K_GAP, 3);
        finish_gap(3);

        // Next inside a gap wraps ch4 -> ch0
        cyc(1'b0, 1'b0, 0, 1'b1, '0, K_GAP, 4);
        cyc(1'b0, 1'b0, 0, 1'b1, '0, K_GAP, 0);
        finish_gap(0);

        // Reset on the second gap cycle wins over a load
        cyc(1'b0, 1'b0, 0, 1'b1, '0, K_GAP, 1);
        cyc(1'b1, 1'b1, 4, 1'b0, '0, K_INIT, 0);
        idle(K_START, 0);
        idle(K_PLAY, 0);

        // End-of-song handling on ch1
        cyc(1'b0, 1'b1, 1, 1'b0, '0, K_GAP, 1);
        finish_gap(1);
        cyc(1'b0, 1'b0, 0, 1'b0, 5'b01000, K_PLAY, 1);
`ifdef MUSIC_SEL_AUTO_ADVANCE_EN
        cyc(1'b0, 1'b0, 0, 1'b0, 5'b00010, K_GAP, 2);
        cyc(1'b0, 1'b0, 0, 1'b0, 5'b00100, K_GAP, 2);
        cyc(1'b0, 1'b0, 0, 1'b0, 5'b00100, K_GAP, 2);
        cyc(1'b0, 1'b0, 0, 1'b0, 5'b00100, K_START, 2);
        cyc(1'b0, 1'b0, 0, 1'b0, 5'b00100, K_PLAY, 2);
        idle(K_PLAY, 2);
`else
        cyc(1'b0, 1'b0, 0, 1'b0, 5'b00010, K_PLAY, 1);
        cyc(1'b0, 1'b0, 0, 1'b0, 5'b00010, K_PLAY, 1);
        idle(K_PLAY, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
